// File: rtl/traffic_light_nway.sv
// N-way traffic light controller.
// States: all-red clearance, one way green, that way yellow, night-mode flashing.
// Every output is registered from next-state values; led_way decodes the light register.
module traffic_light_nway #(
   parameter int unsigned N_WAY      = 4,
   parameter int unsigned GREEN_CYC  = 8,
   parameter int unsigned YELLOW_CYC = 3,
   parameter int unsigned ALLRED_CYC = 2,
   parameter int unsigned FLASH_CYC  = 4
) (
   input  logic                 clk,
   input  logic                 glob_rst,
   input  logic [N_WAY-1:0]     req,
   input  logic                 flash_mode,
   output logic [2*N_WAY-1:0]   light,
   output logic [7*N_WAY-1:0]   led_way,
   output logic [2:0]           active_way,
   output logic                 phase_done
);

   localparam int unsigned MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
   localparam int unsigned MAX_AF  = (ALLRED_CYC > FLASH_CYC) ? ALLRED_CYC : FLASH_CYC;
   localparam int unsigned MAX_CYC = (MAX_GY > MAX_AF) ? MAX_GY : MAX_AF;
   // Counter only ever holds duration-1, so clog2 of the largest duration suffices.
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_CYC - 1);

   localparam logic [1:0] LC_GREEN  = 2'b00;
   localparam logic [1:0] LC_YELLOW = 2'b01;
   localparam logic [1:0] LC_RED    = 2'b10;
   localparam logic [1:0] LC_DARK   = 2'b11;

   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2,
      ST_FLASH  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           active_q, active_d;
   logic                 blink_q, blink_d;
   logic [2*N_WAY-1:0]   light_q, light_d;
   logic                 phase_done_q, phase_done_d;

   logic                 found;
   logic [2:0]           next_way;
   logic                 other_req;

   // Round-robin search upward from active_way+1, ending with active_way itself.
   always_comb begin
      found    = 1'b0;
      next_way = active_q;
      for (int k = 1; k <= int'(N_WAY); k++) begin
         int idx;
         idx = int'(active_q) + k;
         if (idx >= int'(N_WAY)) idx = idx - int'(N_WAY);
         if (!found && req[idx]) begin
            found    = 1'b1;
            next_way = 3'(idx);
         end
      end
   end

   // Any way other than the green one asking for service.
   always_comb begin
      other_req = |(req & ~(N_WAY'(1) << active_q));
   end

   // Next-state, counter, blink and registered-output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      blink_d  = blink_q;
      unique case (state_q)
         ST_ALLRED: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (flash_mode) begin
               state_d = ST_FLASH;
               cnt_d   = LD_FLASH;
               blink_d = 1'b1;
            end else if (found) begin
               state_d  = ST_GREEN;
               cnt_d    = LD_GREEN;
               active_d = next_way;
            end
         end
         ST_GREEN: begin
            if (flash_mode || ((cnt_q == '0) && other_req)) begin
               state_d = ST_YELLOW;
               cnt_d   = LD_YELLOW;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_YELLOW: begin
            if (cnt_q == '0) begin
               state_d = ST_ALLRED;
               cnt_d   = LD_ALLRED;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_FLASH: begin
            if (!flash_mode) begin
               state_d = ST_ALLRED;
               cnt_d   = LD_ALLRED;
            end else if (cnt_q == '0) begin
               cnt_d   = LD_FLASH;
               blink_d = ~blink_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_ALLRED;
            cnt_d   = LD_ALLRED;
         end
      endcase

      phase_done_d = (state_d == ST_YELLOW) && (cnt_d == '0);

      light_d = '0;
      for (int i = 0; i < int'(N_WAY); i++) begin
         unique case (state_d)
            ST_GREEN:  light_d[2*i +: 2] = (active_d == 3'(i)) ? LC_GREEN  : LC_RED;
            ST_YELLOW: light_d[2*i +: 2] = (active_d == 3'(i)) ? LC_YELLOW : LC_RED;
            ST_FLASH:  light_d[2*i +: 2] = blink_d ? LC_YELLOW : LC_DARK;
            default:   light_d[2*i +: 2] = LC_RED;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (glob_rst) begin
         state_q      <= ST_ALLRED;
         cnt_q        <= LD_ALLRED;
         active_q     <= 3'(N_WAY - 1);
         blink_q      <= 1'b0;
         light_q      <= {N_WAY{LC_RED}};
         phase_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         blink_q      <= blink_d;
         light_q      <= light_d;
         phase_done_q <= phase_done_d;
      end
   end

   // Seven-segment decode of each way's light code.
   always_comb begin
      led_way = '0;
      for (int i = 0; i < int'(N_WAY); i++) begin
         unique case (light_q[2*i +: 2])
            LC_GREEN:  led_way[7*i +: 7] = 7'b0000001;
            LC_YELLOW: led_way[7*i +: 7] = 7'b1001111;
            LC_RED:    led_way[7*i +: 7] = 7'b0010010;
            default:   led_way[7*i +: 7] = 7'b1111111;
         endcase
      end
   end

   assign light      = light_q;
   assign active_way = active_q;
   assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_light_nway.sv
// Directed bench for traffic_light_nway with default parameters (4 ways).
module tb_traffic_light_nway;

   logic        clk;
   logic        glob_rst;
   logic [3:0]  req;
   logic        flash_mode;
   logic [7:0]  light;
   logic [27:0] led_way;
   logic [2:0]  active_way;
   logic        phase_done;

   int checks = 0;
   int errors = 0;

   traffic_light_nway dut (
      .clk        (clk),
      .glob_rst   (glob_rst),
      .req        (req),
      .flash_mode (flash_mode),
      .light      (light),
      .led_way    (led_way),
      .active_way (active_way),
      .phase_done (phase_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       flash;
      int         n;
      logic [7:0] light;
      logic [2:0] act;
      logic       pd;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic r, logic [3:0] q, logic f, int n,
                               logic [7:0] l, logic [2:0] a, logic p);
      vec_t v;
      v.rst = r; v.req = q; v.flash = f; v.n = n;
      v.light = l; v.act = a; v.pd = p;
      return v;
   endfunction

   function automatic logic [6:0] seg(logic [1:0] code);
      case (code)
         2'b00:   return 7'b0000001;
         2'b01:   return 7'b1001111;
         2'b10:   return 7'b0010010;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [27:0] led_of(logic [7:0] l);
      logic [27:0] r;
      for (int i = 0; i < 4; i++) r[7*i +: 7] = seg(l[2*i +: 2]);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [7:0] el, logic [2:0] ea, logic ep);
      logic [27:0] eled;
      eled = led_of(el);
      checks++;
      if (light !== el) begin
         errors++;
         $display("FAIL %s light: got %b want %b", name, light, el);
      end
      checks++;
      if (led_way !== eled) begin
         errors++;
         $display("FAIL %s led_way: got %h want %h", name, led_way, eled);
      end
      checks++;
      if (active_way !== ea) begin
         errors++;
         $display("FAIL %s active_way: got %0d want %0d", name, active_way, ea);
      end
      checks++;
      if (phase_done !== ep) begin
         errors++;
         $display("FAIL %s phase_done: got %b want %b", name, phase_done, ep);
      end
   endtask

   initial begin
      bit seen;
      glob_rst   = 1'b1;
      req        = 4'b0000;
      flash_mode = 1'b0;

      // Reset, sole requester, extended green, then handover to way2.
      vq.push_back(mk(1, 4'b0001, 0,  1, 8'hAA, 3'd3, 0));
      vq.push_back(mk(0, 4'b0001, 0,  1, 8'hAA, 3'd3, 0));
      vq.push_back(mk(0, 4'b0001, 0, 12, 8'hA8, 3'd0, 0));
      vq.push_back(mk(0, 4'b0101, 0,  2, 8'hA9, 3'd0, 0));
      vq.push_back(mk(0, 4'b0101, 0,  1, 8'hA9, 3'd0, 1));
      vq.push_back(mk(0, 4'b0101, 0,  2, 8'hAA, 3'd0, 0));
      vq.push_back(mk(0, 4'b0101, 0,  1, 8'h8A, 3'd2, 0));
      // Exact 8-cycle green with competing request arriving in cycle 3.
      vq.push_back(mk(1, 4'b0001, 0,  1, 8'hAA, 3'd3, 0));
      vq.push_back(mk(0, 4'b0001, 0,  1, 8'hAA, 3'd3, 0));
      vq.push_back(mk(0, 4'b0001, 0,  2, 8'hA8, 3'd0, 0));
      vq.push_back(mk(0, 4'b0101, 0,  6, 8'hA8, 3'd0, 0));
      vq.push_back(mk(0, 4'b0101, 0,  2, 8'hA9, 3'd0, 0));
      vq.push_back(mk(0, 4'b0101, 0,  1, 8'hA9, 3'd0, 1));
      vq.push_back(mk(0, 4'b0101, 0,  2, 8'hAA, 3'd0, 0));
      vq.push_back(mk(0, 4'b0101, 0,  1, 8'h8A, 3'd2, 0));
      // Way2 -> way3.
      vq.push_back(mk(0, 4'b1000, 0,  7, 8'h8A, 3'd2, 0));
      vq.push_back(mk(0, 4'b1000, 0,  2, 8'h9A, 3'd2, 0));
      vq.push_back(mk(0, 4'b1000, 0,  1, 8'h9A, 3'd2, 1));
      vq.push_back(mk(0, 4'b1000, 0,  2, 8'hAA, 3'd2, 0));
      vq.push_back(mk(0, 4'b1000, 0,  1, 8'h2A, 3'd3, 0));
      // Way3 -> wrap to way0 with req=0011.
      vq.push_back(mk(0, 4'b0011, 0,  7, 8'h2A, 3'd3, 0));
      vq.push_back(mk(0, 4'b0011, 0,  2, 8'h6A, 3'd3, 0));
      vq.push_back(mk(0, 4'b0011, 0,  1, 8'h6A, 3'd3, 1));
      vq.push_back(mk(0, 4'b0011, 0,  2, 8'hAA, 3'd3, 0));
      vq.push_back(mk(0, 4'b0011, 0,  1, 8'hA8, 3'd0, 0));
      // Night mode forced in green cycle 2, blink, then exit.
      vq.push_back(mk(0, 4'b0011, 0,  1, 8'hA8, 3'd0, 0));
      vq.push_back(mk(0, 4'b0011, 1,  2, 8'hA9, 3'd0, 0));
      vq.push_back(mk(0, 4'b0011, 1,  1, 8'hA9, 3'd0, 1));
      vq.push_back(mk(0, 4'b0011, 1,  2, 8'hAA, 3'd0, 0));
      vq.push_back(mk(0, 4'b0011, 1,  4, 8'h55, 3'd0, 0));
      vq.push_back(mk(0, 4'b0011, 1,  4, 8'hFF, 3'd0, 0));
      vq.push_back(mk(0, 4'b0011, 1,  4, 8'h55, 3'd0, 0));
      vq.push_back(mk(0, 4'b0011, 0,  2, 8'hAA, 3'd0, 0));
      vq.push_back(mk(0, 4'b0011, 0,  1, 8'hA2, 3'd1, 0));

      foreach (vq[i]) begin
         for (int c = 0; c < vq[i].n; c++) begin
            glob_rst   = vq[i].rst;
            req        = vq[i].req;
            flash_mode = vq[i].flash;
            step();
            check($sformatf("vec%0d.%0d", i, c), vq[i].light, vq[i].act, vq[i].pd);
         end
      end

      // Reset during yellow of way1: immediate all-red, full clearance restart.
      glob_rst = 1'b0;
      req      = 4'b0011;
      seen     = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         step();
         if (light === 8'hA6) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL yel_wait: way1 yellow not seen within 40 cycles, light=%b want %b", light, 8'hA6);
      end
      glob_rst = 1'b1;
      step();
      check("rst_in_yellow", 8'hAA, 3'd3, 1'b0);
      glob_rst = 1'b0;
      step();
      check("rst_clear1", 8'hAA, 3'd3, 1'b0);
      step();
      check("rst_service", 8'hA8, 3'd0, 1'b0);

      // Idle hold in all-red, then single request served on the next edge.
      glob_rst = 1'b1;
      req      = 4'b0000;
      step();
      check("idle_rst", 8'hAA, 3'd3, 1'b0);
      glob_rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         check($sformatf("idle%0d", c), 8'hAA, 3'd3, 1'b0);
      end
      req = 4'b1000;
      step();
      check("idle_wake", 8'h2A, 3'd3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
